// File: rtl/clock_time_keeper_pkg.sv
// Shared definitions for the time-of-day core: set-mode encodings, field
// limits and the BCD digit type.
package digital_clock_pkg;

  localparam int unsigned DIGIT_W = 4;

  localparam int unsigned SEC_MAX = 59;
  localparam int unsigned MIN_MAX = 59;
  localparam int unsigned HR_MAX  = 23;

  typedef logic [DIGIT_W-1:0] digit_t;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2
  } state_t;

endpackage

// File: rtl/clock_time_keeper_if.sv
// Button inputs and display outputs of the time keeper.
//   mode_btn, inc_btn : debounced clk-synchronous button levels
//   hr_tens..min_ones : BCD display digits (left to right)
//   sec_pulse         : one-cycle pulse per second in RUN
//   colon             : seconds-ones LSB for colon blink
//   set_mode          : 0=RUN, 1=SET_HR, 2=SET_MIN
interface clock_time_keeper_if;
  import digital_clock_pkg::*;

  logic        mode_btn;
  logic        inc_btn;
  digit_t      hr_tens;
  digit_t      hr_ones;
  digit_t      min_tens;
  digit_t      min_ones;
  logic        sec_pulse;
  logic        colon;
  logic [1:0]  set_mode;

  modport master (
    output mode_btn, inc_btn,
    input  hr_tens, hr_ones, min_tens, min_ones, sec_pulse, colon, set_mode
  );

  modport slave (
    input  mode_btn, inc_btn,
    output hr_tens, hr_ones, min_tens, min_ones, sec_pulse, colon, set_mode
  );

endinterface

// File: rtl/clock_time_keeper_bcd_mod_counter.sv
// Two-digit BCD counter wrapping at MODULUS-1 back to 00.
//   clk, clr  : clock, asynchronous active-high clear
//   load_zero : synchronous clear (wins over inc)
//   inc       : advance by one
//   tens/ones : BCD value
//   carry     : combinational, inc while value is MODULUS-1
module bcd_mod_counter
  import digital_clock_pkg::*;
#(
  parameter int unsigned MODULUS = 60
) (
  input  logic   clk,
  input  logic   clr,
  input  logic   load_zero,
  input  logic   inc,
  output digit_t tens,
  output digit_t ones,
  output logic   carry
);

  localparam digit_t TENS_LAST = DIGIT_W'((MODULUS - 1) / 10);
  localparam digit_t ONES_LAST = DIGIT_W'((MODULUS - 1) % 10);
  localparam digit_t NINE      = DIGIT_W'(9);

  logic at_last;

  assign at_last = (tens == TENS_LAST) && (ones == ONES_LAST);
  assign carry   = inc && at_last;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      tens <= '0;
      ones <= '0;
    end else if (load_zero) begin
      tens <= '0;
      ones <= '0;
    end else if (inc) begin
      if (at_last) begin
        tens <= '0;
        ones <= '0;
      end else if (ones == NINE) begin
        tens <= tens + DIGIT_W'(1);
        ones <= '0;
      end else begin
        ones <= ones + DIGIT_W'(1);
      end
    end
  end

endmodule

// File: rtl/clock_time_keeper.sv
// 24-hour BCD time keeper with 1 Hz prescaler and two-button set mode.
//   clk  : board clock
//   clr  : asynchronous active-high reset
//   bus  : buttons in, display digits / sec_pulse / colon / set_mode out
module clock_time_keeper
  import digital_clock_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100_000_000
) (
  input  logic                  clk,
  input  logic                  clr,
  clock_time_keeper_if.slave    bus
);

  localparam int unsigned          PRESC_W    = $clog2(TICK_DIV);
  localparam logic [PRESC_W-1:0]   PRESC_LAST = PRESC_W'(TICK_DIV - 1);

  state_t               state_q;
  state_t               next_state;
  logic [PRESC_W-1:0]   presc_q;
  logic                 mode_q;
  logic                 inc_q;
  logic                 mode_rise;
  logic                 inc_rise;
  logic                 sec_pulse_q;

  logic                 hold_c;
  logic                 tick_c;
  logic                 inc_ok_c;
  logic                 min_inc_c;
  logic                 hr_inc_c;

  logic                 sec_carry;
  logic                 min_carry;
  logic                 hr_carry;
  digit_t               sec_tens;
  digit_t               sec_ones;
  digit_t               min_tens;
  digit_t               min_ones;
  digit_t               hr_tens;
  digit_t               hr_ones;

  // Registered rising-edge detect on both buttons.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      mode_q    <= 1'b0;
      inc_q     <= 1'b0;
      mode_rise <= 1'b0;
      inc_rise  <= 1'b0;
    end else begin
      mode_q    <= bus.mode_btn;
      inc_q     <= bus.inc_btn;
      mode_rise <= bus.mode_btn & ~mode_q;
      inc_rise  <= bus.inc_btn & ~inc_q;
    end
  end

  // Set-mode state register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) state_q <= RUN;
    else     state_q <= next_state;
  end

  // Mode sequencing; time is frozen whenever either side of the edge is a set mode.
  always_comb begin
    next_state = state_q;
    hold_c     = 1'b0;
    tick_c     = 1'b0;
    case (state_q)
      RUN:     if (mode_rise) next_state = SET_HR;
      SET_HR:  if (mode_rise) next_state = SET_MIN;
      SET_MIN: if (mode_rise) next_state = RUN;
      default: next_state = RUN;
    endcase
    hold_c = (state_q != RUN) || (next_state != RUN);
    tick_c = !hold_c && (presc_q == PRESC_LAST);
  end

  // A mode edge in the same cycle swallows the inc edge.
  assign inc_ok_c  = inc_rise & ~mode_rise;
  // Minute carry never reaches hours while setting minutes.
  assign min_inc_c = (state_q == RUN) ? sec_carry : ((state_q == SET_MIN) && inc_ok_c);
  assign hr_inc_c  = (state_q == RUN) ? min_carry : ((state_q == SET_HR)  && inc_ok_c);

  // 1 Hz prescaler and registered tick pulse.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      presc_q     <= '0;
      sec_pulse_q <= 1'b0;
    end else begin
      sec_pulse_q <= tick_c;
      if (hold_c || (presc_q == PRESC_LAST)) presc_q <= '0;
      else                                   presc_q <= presc_q + PRESC_W'(1);
    end
  end

  bcd_mod_counter #(.MODULUS(SEC_MAX + 1)) u_sec (
    .clk       (clk),
    .clr       (clr),
    .load_zero (hold_c),
    .inc       (tick_c),
    .tens      (sec_tens),
    .ones      (sec_ones),
    .carry     (sec_carry)
  );

  bcd_mod_counter #(.MODULUS(MIN_MAX + 1)) u_min (
    .clk       (clk),
    .clr       (clr),
    .load_zero (1'b0),
    .inc       (min_inc_c),
    .tens      (min_tens),
    .ones      (min_ones),
    .carry     (min_carry)
  );

  bcd_mod_counter #(.MODULUS(HR_MAX + 1)) u_hr (
    .clk       (clk),
    .clr       (clr),
    .load_zero (1'b0),
    .inc       (hr_inc_c),
    .tens      (hr_tens),
    .ones      (hr_ones),
    .carry     (hr_carry)
  );

  // Seconds tens and the hour carry have no consumer.
  logic unused_ok;
  assign unused_ok = ^{sec_tens, sec_ones[DIGIT_W-1:1], hr_carry};

  assign bus.hr_tens   = hr_tens;
  assign bus.hr_ones   = hr_ones;
  assign bus.min_tens  = min_tens;
  assign bus.min_ones  = min_ones;
  assign bus.sec_pulse = sec_pulse_q;
  assign bus.colon     = sec_ones[0];
  assign bus.set_mode  = state_q;

endmodule

// File: tb/tb_clock_time_keeper.sv
// Scoreboard bench for clock_time_keeper with TICK_DIV=4. Stimulus pushes the
// expected display state and cycle of every visible event; a monitor pops one
// entry whenever sec_pulse is high or any display output changes.
module tb_clock_time_keeper;
  import digital_clock_pkg::*;

  localparam int unsigned TICK_DIV = 4;

  logic clk = 1'b0;
  logic clr = 1'b1;

  clock_time_keeper_if bus();

  clock_time_keeper #(.TICK_DIV(TICK_DIV)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;     // -1: any cycle
    int hr;
    int mn;
    int mode;
    bit colon;
    bit pulse;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  logic [18:0] prev_obs = '1;

  function automatic void push_exp(int c, int hr, int mn, int md, bit cl, bit pl);
    exp_t e;
    e.cyc = c; e.hr = hr; e.mn = mn; e.mode = md; e.colon = cl; e.pulse = pl;
    sb.push_back(e);
  endfunction

  // Monitor: sample after each falling edge and right after clr rises.
  initial begin
    logic [18:0] obs;
    logic [18:0] want;
    exp_t        e;
    forever begin
      @(negedge clk or posedge clr);
      #1;
      obs = {bus.hr_tens, bus.hr_ones, bus.min_tens, bus.min_ones, bus.set_mode, bus.colon};
      if (bus.sec_pulse === 1'b1 || obs !== prev_obs) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_event cyc=%0d got=%h pulse=%b required=none", cyc, obs, bus.sec_pulse);
        end else begin
          e    = sb.pop_front();
          want = {4'(e.hr / 10), 4'(e.hr % 10), 4'(e.mn / 10), 4'(e.mn % 10), 2'(e.mode), e.colon};
          if (obs !== want || bus.sec_pulse !== e.pulse || (e.cyc >= 0 && cyc != e.cyc)) begin
            bad++;
            $display("FAIL event cyc=%0d got=%h pulse=%b required=%h pulse=%b at cyc=%0d",
                     cyc, obs, bus.sec_pulse, want, e.pulse, e.cyc);
          end
        end
        prev_obs = obs;
      end
    end
  end

  task automatic to_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // One button pulse of one cycle; expected change lands two cycles later.
  task automatic press(input bit pm, input bit pi, input int hr, input int mn, input int md);
    push_exp(cyc + 2, hr, mn, md, 1'b0, 1'b0);
    bus.mode_btn = pm;
    bus.inc_btn  = pi;
    @(negedge clk);
    bus.mode_btn = 1'b0;
    bus.inc_btn  = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int n;
    int e;
    bus.mode_btn = 1'b0;
    bus.inc_btn  = 1'b0;

    // Reset held three cycles, then first ticks every 4 cycles.
    push_exp(-1, 0, 0, 0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    n   = cyc;
    clr = 1'b0;
    for (int k = 1; k <= 3; k++) push_exp(n + 4 * k, 0, 0, 0, 1'(k % 2), 1'b1);
    to_cyc(n + 12);

    // Set 23:59 and roll over in RUN.
    press(1'b1, 1'b0, 0, 0, 1);
    for (int h = 1; h <= 23; h++) press(1'b0, 1'b1, h, 0, 1);
    press(1'b1, 1'b0, 23, 0, 2);
    for (int m = 1; m <= 59; m++) press(1'b0, 1'b1, 23, m, 2);
    press(1'b1, 1'b0, 23, 59, 0);
    e = cyc;
    for (int k = 1; k <= 60; k++) begin
      if (k == 60) push_exp(e + 4 * k, 0, 0, 0, 1'b0, 1'b1);
      else         push_exp(e + 4 * k, 23, 59, 0, 1'(k % 2), 1'b1);
    end
    to_cyc(e + 240);

    // Minutes wrap in SET_MIN without touching hours.
    press(1'b1, 1'b0, 0, 0, 1);
    for (int h = 1; h <= 12; h++) press(1'b0, 1'b1, h, 0, 1);
    press(1'b1, 1'b0, 12, 0, 2);
    for (int m = 1; m <= 58; m++) press(1'b0, 1'b1, 12, m, 2);
    press(1'b0, 1'b1, 12, 59, 2);
    press(1'b0, 1'b1, 12, 0, 2);
    press(1'b0, 1'b1, 12, 1, 2);
    press(1'b1, 1'b0, 12, 1, 0);

    // Hours wrap in SET_HR from 22:30; idle in set mode produces no pulse.
    press(1'b1, 1'b0, 12, 1, 1);
    for (int h = 13; h <= 22; h++) press(1'b0, 1'b1, h, 1, 1);
    press(1'b1, 1'b0, 22, 1, 2);
    for (int m = 2; m <= 30; m++) press(1'b0, 1'b1, 22, m, 2);
    press(1'b1, 1'b0, 22, 30, 0);
    press(1'b1, 1'b0, 22, 30, 1);
    press(1'b0, 1'b1, 23, 30, 1);
    press(1'b0, 1'b1, 0, 30, 1);
    repeat (12) @(negedge clk);

    // Reach 05:00 in SET_HR.
    for (int h = 1; h <= 5; h++) press(1'b0, 1'b1, h, 30, 1);
    press(1'b1, 1'b0, 5, 30, 2);
    for (int m = 31; m <= 59; m++) press(1'b0, 1'b1, 5, m, 2);
    press(1'b0, 1'b1, 5, 0, 2);
    press(1'b1, 1'b0, 5, 0, 0);
    press(1'b1, 1'b0, 5, 0, 1);

    // Simultaneous mode+inc: mode wins; inc stays held without effect.
    push_exp(cyc + 2, 5, 0, 2, 1'b0, 1'b0);
    bus.mode_btn = 1'b1;
    bus.inc_btn  = 1'b1;
    @(negedge clk);
    bus.mode_btn = 1'b0;
    repeat (6) @(negedge clk);
    bus.inc_btn = 1'b0;
    repeat (2) @(negedge clk);

    // A long inc hold gives a single increment.
    push_exp(cyc + 2, 5, 1, 2, 1'b0, 1'b0);
    bus.inc_btn = 1'b1;
    repeat (8) @(negedge clk);
    bus.inc_btn = 1'b0;
    @(negedge clk);

    // Run from 07:42:00 to :31, then clear between edges.
    press(1'b1, 1'b0, 5, 1, 0);
    press(1'b1, 1'b0, 5, 1, 1);
    press(1'b0, 1'b1, 6, 1, 1);
    press(1'b0, 1'b1, 7, 1, 1);
    press(1'b1, 1'b0, 7, 1, 2);
    for (int m = 2; m <= 42; m++) press(1'b0, 1'b1, 7, m, 2);
    press(1'b1, 1'b0, 7, 42, 0);
    e = cyc;
    for (int k = 1; k <= 31; k++) push_exp(e + 4 * k, 7, 42, 0, 1'(k % 2), 1'b1);
    to_cyc(e + 124);
    repeat (2) @(negedge clk);
    push_exp(cyc, 0, 0, 0, 1'b0, 1'b0);
    #2;
    clr = 1'b1;
    repeat (2) @(negedge clk);
    n   = cyc;
    clr = 1'b0;
    push_exp(n + 4, 0, 0, 0, 1'b1, 1'b1);
    push_exp(n + 8, 0, 0, 0, 1'b0, 1'b1);
    to_cyc(n + 8);

    // Drain with a bounded wait; leftovers are missed events.
    for (int i = 0; i < 20; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    #2;
    while (sb.size() > 0) begin
      exp_t m;
      m = sb.pop_front();
      total++;
      bad++;
      $display("FAIL missing_event got=none required=%0d:%0d mode=%0d at cyc=%0d", m.hr, m.mn, m.mode, m.cyc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    total++;
    bad++;
    $display("FAIL watchdog got=timeout required=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clock_time_keeper.md
# clock_time_keeper

Time-of-day core for the BASYS3 digital clock. It divides the 100 MHz board clock into a 1 Hz tick and keeps a 24-hour HH:MM:SS count in BCD. It also provides a two-button set mode. Its four BCD digit outputs drive the seven-segment driver inputs directly: hours tens to the leftmost digit, minutes ones to the rightmost.

## Interface
- `TICK_DIV`, default 100_000_000: clk cycles per second; must be ≥ 2 (benches use 4).
- `clk`  in  1  board clock, all logic on rising edge.
- `clr`  in  1  reset, asynchronous, active-high.
- `mode_btn`  in  1  debounced, clk-synchronous level; rising edge advances set mode.
- `inc_btn`  in  1  debounced, clk-synchronous level; rising edge increments selected field.
- `hr_tens`  out  4  BCD 0–2.
- `hr_ones`  out  4  BCD 0–9 (0–3 when `hr_tens`=2).
- `min_tens`  out  4  BCD 0–5.
- `min_ones`  out  4  BCD 0–9.
- `sec_pulse`  out  1  one-cycle pulse on each 1 Hz tick in RUN.
- `colon`  out  1  seconds-ones LSB, used for colon blink.
- `set_mode`  out  2  0=RUN, 1=SET_HR, 2=SET_MIN.

## Operation
- Reset (`clr`=1, asynchronous) forces all of the following, held while `clr`=1:
  - all digits, seconds, prescaler, `sec_pulse`, `colon` = 0
  - state = RUN, `set_mode`=0
  - button edge registers = 0
- Edge detect: a registered copy of each button is kept; an edge is `btn & ~btn_q`. A level held high yields exactly one edge.
- State machine, on a `mode_btn` edge: RUN→SET_HR→SET_MIN→RUN.
  - Leaving SET_MIN clears seconds and the prescaler, so the time restarts at :00.
- RUN:
  - Prescaler counts 0..TICK_DIV-1 and wraps.
  - At count TICK_DIV-1, seconds increment.
  - 59→0 carries to minutes; minute 59→0 carries to hours; hour 23→0.
  - 23:59:59 wraps to 00:00:00.
  - `inc_btn` edges are ignored.
- SET_HR:
  - Prescaler and seconds are held at 0; no time advance.
  - `inc_btn` edge: hours +1 mod 24. Minutes are untouched.
- SET_MIN:
  - Prescaler and seconds are held at 0.
  - `inc_btn` edge: minutes +1 mod 60, with no carry into hours (59→00, hours unchanged).
- Simultaneous `mode_btn` and `inc_btn` edges in the same cycle: the mode transition wins and the inc is discarded.
- BCD rules:
  - Ones digit 9→0 increments tens.
  - Hours wrap is checked as tens=2 and ones=3, giving 00.
  - Digits never hold a non-BCD value.

## Timing
- `sec_pulse` is registered: it is high for the cycle after the prescaler reaches TICK_DIV-1. The digit and `colon` updates are visible on that same cycle.
- First tick after reset or after leaving SET_MIN: exactly TICK_DIV cycles later.
- Button edge to digit change: 2 cycles (1 for edge register, 1 for counter update).
- Button edge to `set_mode` change: 2 cycles.
- `clr` asserted mid-count or mid-set: outputs go to reset values asynchronously. Operation resumes in RUN from 00:00:00 on the first clk edge after deassertion.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package `digital_clock_pkg` holds:
  - state encodings RUN/SET_HR/SET_MIN (2-bit)
  - constants SEC_MAX=59, MIN_MAX=59, HR_MAX=23
  - the BCD digit width (4)
- Sub-module `bcd_mod_counter`:
  - two-digit BCD counter with parameter `MODULUS` (60 or 24)
  - ports `clk`, `clr`, `load_zero`, `inc`, tens/ones outputs, and `carry` (combinational, high when `inc` and the value is MODULUS-1)
  - instantiated three times (seconds, minutes, hours)
  - in SET_MIN the minutes `carry` is masked from the hours `inc`.
- The top module contains the prescaler, edge detectors, FSM and output registers.

## Test plan
- Reset with TICK_DIV=4: hold `clr` 3 cycles → all digits 0, `set_mode`=0; first `sec_pulse` 4 cycles after release; `colon` toggles each pulse.
- Full rollover: set 23:59 via buttons, return to RUN, run 60 ticks → display 00:00 on tick 60, `sec_pulse` never skipped.
- SET_MIN wrap: in SET_MIN from 12:58, press inc 3 times → 12:59, 12:00, 12:01; hours stay 12.
- SET_HR wrap: from 22:30, press inc 2 times → 23:30 then 00:30; no `sec_pulse` while in set mode.
- Simultaneous edges: in SET_HR at 05:00, rise `mode_btn` and `inc_btn` on the same cycle → `set_mode`=2, hours stay 05. A held `inc_btn` produces exactly one increment.
- Async reset mid-count: at 07:42:31 assert `clr` between clk edges → outputs zero immediately, before the next edge; RUN resumes from 00:00:00.
